// File: rtl/prog_pkg.sv
// Shared FSM encoding and timing defaults for the serial programming arbiter.
package prog_pkg;

  localparam int DIV_DEF     = 16;
  localparam int TIMEOUT_DEF = 64;
  localparam int RSTCYC_DEF  = 4;

  typedef enum logic [2:0] {
    sRESET = 3'd0,
    sIDLE  = 3'd1,
    sSHIFT = 3'd2,
    sWAIT  = 3'd3,
    sDONE  = 3'd4
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: one-hot grant to the first requester after last_idx, wrapping.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_idx,
  output logic [NREQ-1:0] grant
);

  always_comb begin
    int j;
    j     = 0;
    grant = '0;
    for (int i = 1; i <= NREQ; i++) begin
      j = int'(last_idx) + i;
      if (j >= NREQ) j = j - NREQ;
      if ((grant == '0) && req[j]) grant[j] = 1'b1;
    end
  end

endmodule

// File: rtl/serial_prog_arbiter.sv
// Arbitrates configuration requesters onto a serial chip programming port and
// waits for the chip's ready handshake (or a timeout) per programmed word.
//
// state  | meaning
// sRESET | chip reset held low for RSTCYC cycles after i_reset
// sIDLE  | no frame in flight; pick next requester round-robin
// sSHIFT | word shifted out MSB first, sclk low then high per bit
// sWAIT  | waiting for a rising edge of synchronized i_ready
// sDONE  | one-cycle completion pulse on o_done
module serial_prog_arbiter
  import prog_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 5,
  parameter int DIV     = DIV_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int RSTCYC  = RSTCYC_DEF
) (
  input  logic                  i_mainclk,
  input  logic                  i_reset,
  input  logic [NREQ-1:0]       i_req,
  input  logic [NREQ*WIDTH-1:0] i_data,
  input  logic                  i_ready,
  output logic [NREQ-1:0]       o_grant,
  output logic [NREQ-1:0]       o_done,
  output logic [NREQ-1:0]       o_err,
  output logic                  o_busy,
  output logic                  o_resetbAll,
  output logic                  o_sclk,
  output logic                  o_sdout
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int DW = $clog2(DIV + 1);
  localparam int BW = $clog2(WIDTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(RSTCYC + 1);

  state_t            state, state_nx;
  logic [NREQ-1:0]   grant, grant_nx;
  logic [NREQ-1:0]   err, err_nx;
  logic [IW-1:0]     last_idx, last_idx_nx;
  logic              last_vld, last_vld_nx;
  logic [WIDTH-1:0]  sreg, sreg_nx;
  logic              sclk, sclk_nx;
  logic              sdout, sdout_nx;
  logic [DW-1:0]     div_cnt, div_cnt_nx;
  logic [BW-1:0]     bit_cnt, bit_cnt_nx;
  logic [TW-1:0]     tmr, tmr_nx;
  logic [RW-1:0]     rst_cnt, rst_cnt_nx;
  logic              rdy_s1, rdy_s2, rdy_d;
  logic              rdy_rise;
  logic [IW-1:0]     rr_last;
  logic [NREQ-1:0]   rr_grant;
  logic [IW-1:0]     rr_idx;
  logic [WIDTH-1:0]  rr_word;

  // Before any grant the search must start at index 0, i.e. "last" = NREQ-1.
  assign rr_last  = last_vld ? last_idx : IW'(NREQ - 1);
  assign rdy_rise = rdy_s2 & ~rdy_d;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr (
    .req      (i_req),
    .last_idx (rr_last),
    .grant    (rr_grant)
  );

  always_comb begin
    rr_idx  = '0;
    rr_word = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (rr_grant[k]) begin
        rr_idx  = IW'(k);
        rr_word = i_data[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_nx    = state;
    grant_nx    = grant;
    err_nx      = '0;
    last_idx_nx = last_idx;
    last_vld_nx = last_vld;
    sreg_nx     = sreg;
    sclk_nx     = sclk;
    sdout_nx    = sdout;
    div_cnt_nx  = div_cnt;
    bit_cnt_nx  = bit_cnt;
    tmr_nx      = tmr;
    rst_cnt_nx  = rst_cnt;

    case (state)
      sRESET: begin
        sclk_nx  = 1'b1;
        sdout_nx = 1'b0;
        grant_nx = '0;
        if (rst_cnt == '0) state_nx = sIDLE;
        else               rst_cnt_nx = rst_cnt - 1'b1;
      end
      sIDLE: begin
        if (|i_req) begin
          grant_nx    = rr_grant;
          last_idx_nx = rr_idx;
          last_vld_nx = 1'b1;
          sdout_nx    = rr_word[WIDTH-1];
          sreg_nx     = rr_word << 1;
          sclk_nx     = 1'b0;
          div_cnt_nx  = DW'(DIV - 1);
          bit_cnt_nx  = BW'(WIDTH - 1);
          state_nx    = sSHIFT;
        end
      end
      sSHIFT: begin
        if (div_cnt != '0) begin
          div_cnt_nx = div_cnt - 1'b1;
        end else begin
          div_cnt_nx = DW'(DIV - 1);
          if (!sclk) begin
            sclk_nx = 1'b1;
          end else if (bit_cnt == '0) begin
            sdout_nx = 1'b0;
            tmr_nx   = TW'(TIMEOUT - 1);
            state_nx = sWAIT;
          end else begin
            sclk_nx    = 1'b0;
            sdout_nx   = sreg[WIDTH-1];
            sreg_nx    = sreg << 1;
            bit_cnt_nx = bit_cnt - 1'b1;
          end
        end
      end
      sWAIT: begin
        // Completion is checked first so a same-cycle edge beats the timeout.
        if (rdy_rise) begin
          state_nx = sDONE;
        end else if (tmr == '0) begin
          err_nx   = grant;
          grant_nx = '0;
          state_nx = sIDLE;
        end else begin
          tmr_nx = tmr - 1'b1;
        end
      end
      sDONE: begin
        grant_nx = '0;
        state_nx = sIDLE;
      end
      default: state_nx = sRESET;
    endcase
  end

  always_ff @(posedge i_mainclk) begin
    if (i_reset) begin
      state    <= sRESET;
      grant    <= '0;
      err      <= '0;
      last_idx <= '0;
      last_vld <= 1'b0;
      sreg     <= '0;
      sclk     <= 1'b1;
      sdout    <= 1'b0;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      tmr      <= '0;
      rst_cnt  <= RW'(RSTCYC);
      rdy_s1   <= 1'b0;
      rdy_s2   <= 1'b0;
      rdy_d    <= 1'b0;
    end else begin
      state    <= state_nx;
      grant    <= grant_nx;
      err      <= err_nx;
      last_idx <= last_idx_nx;
      last_vld <= last_vld_nx;
      sreg     <= sreg_nx;
      sclk     <= sclk_nx;
      sdout    <= sdout_nx;
      div_cnt  <= div_cnt_nx;
      bit_cnt  <= bit_cnt_nx;
      tmr      <= tmr_nx;
      rst_cnt  <= rst_cnt_nx;
      rdy_s1   <= i_ready;
      rdy_s2   <= rdy_s1;
      rdy_d    <= rdy_s2;
    end
  end

  assign o_grant     = grant;
  assign o_done      = (state == sDONE) ? grant : '0;
  assign o_err       = err;
  assign o_busy      = (state != sIDLE);
  assign o_resetbAll = (state != sRESET);
  assign o_sclk      = sclk;
  assign o_sdout     = sdout;

endmodule
